// File: rtl/vm_pkg.sv
// Shared types, key codes, coin values, price function and seven-segment
// glyphs for the vending machine. Build option VM_EXT_SCAN_EN (see the
// scanner and top files) does not affect this package.
package vm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_QTY    = 3'd2,
        ST_PRICE  = 3'd3,
        ST_PAY    = 3'd4,
        ST_CHANGE = 3'd5
    } vm_state_e;

    localparam logic [3:0] KEY_INC    = 4'hC;
    localparam logic [3:0] KEY_DEC    = 4'hD;
    localparam logic [3:0] KEY_CANCEL = 4'hE;
    localparam logic [3:0] KEY_OK     = 4'hF;

    localparam logic [6:0] COIN_1  = 7'd1;
    localparam logic [6:0] COIN_5  = 7'd5;
    localparam logic [6:0] COIN_10 = 7'd10;
    localparam logic [6:0] COIN_20 = 7'd20;

    localparam logic [3:0] QTY_MAX   = 4'd9;
    localparam logic [7:0] PAID_MAX  = 8'd99;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Item k costs k+1 dollars.
    function automatic logic [3:0] unit_price(input logic [2:0] item);
        return {1'b0, item} + 4'd1;
    endfunction

    // Coin keys 8..B map through their low two bits.
    function automatic logic [6:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd0:    return COIN_1;
            2'd1:    return COIN_5;
            2'd2:    return COIN_10;
            default: return COIN_20;
        endcase
    endfunction

    // Active-low glyphs, bit0 = segment a; anything above 9 is blank.
    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Two digits with leading zero: {tens glyph, ones glyph}.
    function automatic logic [13:0] two_digit(input logic [6:0] v);
        return {seg_glyph(4'(v / 7'd10)), seg_glyph(4'(v % 7'd10))};
    endfunction

    // Index of the single low bit of a one-hot-low nibble.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        case (v)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic one_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column drive, 2-flop row synchronizer,
// press edge detection and key-code output. With VM_EXT_SCAN_EN defined
// the column is supplied from outside and no scan counter is built.
module keypad_scanner
    import vm_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
`ifdef VM_EXT_SCAN_EN
    input  logic [3:0] shift_col,
`else
    output logic [3:0] shift_col,
`endif
    output logic       key_valid,
    output logic [3:0] key_code
);

    logic [3:0] row_meta_q, row_meta_d;
    logic [3:0] row_sync_q, row_sync_d;
    logic [3:0] col_meta_q, col_meta_d;
    logic [3:0] col_sync_q, col_sync_d;
    logic       released_q, released_d;

    // The column is delayed alongside the row so the code pairs matching samples.
    always_comb begin
        row_meta_d = row;
        row_sync_d = row_meta_q;
        col_meta_d = shift_col;
        col_sync_d = col_meta_q;
        released_d = (row_sync_q == 4'hF);
    end

    // Synchronizer and release-tracking flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            col_meta_q <= 4'hE;
            col_sync_q <= 4'hE;
            released_q <= 1'b0;
        end else begin
            row_meta_q <= row_meta_d;
            row_sync_q <= row_sync_d;
            col_meta_q <= col_meta_d;
            col_sync_q <= col_sync_d;
            released_q <= released_d;
        end
    end

    // One pulse per press: a single low row directly after an all-high cycle.
    assign key_valid = one_low(row_sync_q) && released_q;
    assign key_code  = {low_index(col_sync_q), low_index(row_sync_q)};

`ifndef VM_EXT_SCAN_EN
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] div_q, div_d;
    logic [3:0]    col_q, col_d;

    // Rotate the driven column every SCAN_DIV cycles; hold while a key is down.
    always_comb begin
        div_d = div_q;
        col_d = col_q;
        if (row_sync_q == 4'hF) begin
            if (div_q == CW'(SCAN_DIV - 1)) begin
                div_d = '0;
                col_d = {col_q[2:0], col_q[3]};
            end else begin
                div_d = div_q + CW'(1);
            end
        end
    end

    // Scan counter and column register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            col_q <= 4'hE;
        end else begin
            div_q <= div_d;
            col_q <= col_d;
        end
    end

    assign shift_col = col_q;
`endif

endmodule

// File: rtl/vending_machine.sv
// Vending-machine controller: keypad-driven purchase flow shown on six
// active-low seven-segment digits. VM_EXT_SCAN_EN turns shift_col into an
// input and removes the internal column scanner.
module vending_machine
    import vm_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
`ifdef VM_EXT_SCAN_EN
    input  logic [3:0] shift_col,
`else
    output logic [3:0] shift_col,
`endif
    output logic [6:0] D0,
    output logic [6:0] D1,
    output logic [6:0] D2,
    output logic [6:0] D3,
    output logic [6:0] D4,
    output logic [6:0] D5,
    output logic [2:0] state_dbg
);

    logic       key_valid;
    logic [3:0] key_code;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .shift_col (shift_col),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    vm_state_e  state_q, state_d;
    logic       item_valid_q, item_valid_d;
    logic [2:0] item_q, item_d;
    logic [3:0] qty_q, qty_d;
    logic [6:0] paid_q, paid_d;
    logic [7:0] paid_sum;
    logic [6:0] total;
    logic [6:0] change;

    assign total     = {3'b000, unit_price(item_q)} * {3'b000, qty_q};
    assign change    = paid_q - total;
    assign state_dbg = state_q;

    // Purchase flow: next state and register updates on each key event.
    always_comb begin
        state_d      = state_q;
        item_valid_d = item_valid_q;
        item_d       = item_q;
        qty_d        = qty_q;
        paid_d       = paid_q;
        paid_sum     = {1'b0, paid_q} + {1'b0, coin_value(key_code[1:0])};
        if (key_valid) begin
            if (key_code == KEY_CANCEL && state_q != ST_IDLE) begin
                state_d      = ST_IDLE;
                item_valid_d = 1'b0;
                item_d       = '0;
                qty_d        = '0;
                paid_d       = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (key_code == KEY_OK) state_d = ST_SELECT;
                    end
                    ST_SELECT: begin
                        if (!key_code[3]) begin
                            item_valid_d = 1'b1;
                            item_d       = key_code[2:0];
                        end else if (key_code == KEY_OK && item_valid_q) begin
                            state_d = ST_QTY;
                        end
                    end
                    ST_QTY: begin
                        if (key_code == KEY_INC && qty_q < QTY_MAX) qty_d = qty_q + 4'd1;
                        if (key_code == KEY_DEC && qty_q != 4'd0)   qty_d = qty_q - 4'd1;
                        if (key_code == KEY_OK && qty_q != 4'd0)    state_d = ST_PRICE;
                    end
                    ST_PRICE: begin
                        if (key_code == KEY_OK) state_d = ST_PAY;
                    end
                    ST_PAY: begin
                        if (key_code[3:2] == 2'b10)
                            paid_d = (paid_sum > PAID_MAX) ? PAID_MAX[6:0] : paid_sum[6:0];
                        if (key_code == KEY_OK && paid_q >= total) state_d = ST_CHANGE;
                    end
                    ST_CHANGE: begin
                        if (key_code == KEY_OK) begin
                            state_d      = ST_IDLE;
                            item_valid_d = 1'b0;
                            item_d       = '0;
                            qty_d        = '0;
                            paid_d       = '0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Purchase registers; reset aborts any purchase in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            item_valid_q <= 1'b0;
            item_q       <= '0;
            qty_q        <= '0;
            paid_q       <= '0;
        end else begin
            state_q      <= state_d;
            item_valid_q <= item_valid_d;
            item_q       <= item_d;
            qty_q        <= qty_d;
            paid_q       <= paid_d;
        end
    end

    // Display decode straight from the registers.
    always_comb begin
        D5 = seg_glyph({1'b0, state_q});
        D4 = SEG_BLANK;
        D3 = SEG_BLANK;
        D2 = SEG_BLANK;
        D1 = SEG_BLANK;
        D0 = SEG_BLANK;
        case (state_q)
            ST_SELECT: begin
                if (item_valid_q) D4 = seg_glyph({1'b0, item_q});
            end
            ST_QTY: begin
                D4       = seg_glyph({1'b0, item_q});
                {D1, D0} = two_digit({3'b000, qty_q});
            end
            ST_PRICE: begin
                {D3, D2} = two_digit({3'b000, unit_price(item_q)});
                {D1, D0} = two_digit(total);
            end
            ST_PAY: begin
                {D3, D2} = two_digit(total);
                {D1, D0} = two_digit(paid_q);
            end
            ST_CHANGE: begin
                {D3, D2} = two_digit(paid_q);
                {D1, D0} = two_digit(change);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine with a 4x4 keypad matrix model.
module tb_vending_machine;

    localparam int SCAN_DIV = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  shift_col;
    logic [6:0]  D0, D1, D2, D3, D4, D5;
    logic [2:0]  state_dbg;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;

    vending_machine #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .shift_col (shift_col),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .D4        (D4),
        .D5        (D5),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[4*c+r] && !shift_col[c]) row[r] = 1'b0;
    end

    // Hand-written active-low glyphs, bit0 = a; negative means blank.
    function automatic logic [6:0] g(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] disp(input int d5, input int d4, input int d3,
                                         input int d2, input int d1, input int d0);
        return {g(d5), g(d4), g(d3), g(d2), g(d1), g(d0)};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input logic [41:0] exp);
        check(tag, {6'b0, D5, D4, D3, D2, D1, D0}, {6'b0, exp});
    endtask

    task automatic check_state(input string tag, input int exp);
        check(tag, {45'b0, state_dbg}, 48'(exp));
    endtask

    // Press every key in mask together, hold, release, let the machine settle.
    task automatic press_keys(input logic [15:0] mask, input int hold);
        int c;
        int n;
        c = 0;
        for (int i = 15; i >= 0; i--) if (mask[i]) c = i / 4;
`ifdef VM_EXT_SCAN_EN
        shift_col = ~(4'b0001 << c);
        n = 0;
`else
        // Start the press while its column is idle so it is seen from a window start.
        n = 0;
        while (shift_col[c] == 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $error("FAIL col_wait observed %0d cycles expected below 200", n);
        end
`endif
        pressed = mask;
        repeat (4 * SCAN_DIV + 8 + hold) @(negedge clk);
        pressed = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic key(input int k);
        press_keys(16'(1) << k, 0);
    endtask

    initial begin
        pressed = '0;
        reset   = 1'b1;
`ifdef VM_EXT_SCAN_EN
        shift_col = 4'hE;
`endif
        repeat (3) @(negedge clk);
        check_disp("reset_disp", disp(0, -1, -1, -1, -1, -1));
        check_state("reset_state", 0);
`ifndef VM_EXT_SCAN_EN
        check("reset_col", {44'b0, shift_col}, 48'hE);
`endif
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Normal purchase: item 1 ($2) x1, pay $1 + $5
        key(15); check_disp("sel_empty", disp(1, -1, -1, -1, -1, -1));
        key(1);  check_disp("sel_item1", disp(1, 1, -1, -1, -1, -1));
        key(15); check_disp("qty0",      disp(2, 1, -1, -1, 0, 0));
        key(12); check_disp("qty1",      disp(2, 1, -1, -1, 0, 1));
        key(15); check_disp("price",     disp(3, -1, 0, 2, 0, 2));
        key(15); check_disp("pay0",      disp(4, -1, 0, 2, 0, 0));
        key(8);  check_disp("pay1",      disp(4, -1, 0, 2, 0, 1));
        key(9);  check_disp("pay6",      disp(4, -1, 0, 2, 0, 6));
        key(15); check_disp("change4",   disp(5, -1, 0, 6, 0, 4));
        key(15); check_disp("back_idle", disp(0, -1, -1, -1, -1, -1));

        // Underpayment: item 7 ($8) x2 = 16
        key(15); key(7); key(15); key(12); key(12);
        check_disp("qty2", disp(2, 7, -1, -1, 0, 2));
        key(15); check_disp("price16",    disp(3, -1, 0, 8, 1, 6));
        key(15); key(9);
        check_disp("under_pay5", disp(4, -1, 1, 6, 0, 5));
        key(15); check_disp("under_stay", disp(4, -1, 1, 6, 0, 5));
        check_state("under_state", 4);
        key(11); check_disp("pay25",      disp(4, -1, 1, 6, 2, 5));
        key(15); check_disp("change9",    disp(5, -1, 2, 5, 0, 9));
        key(15);

        // Quantity limits
        key(15); key(0); key(15);
        check_disp("qlim_start", disp(2, 0, -1, -1, 0, 0));
        key(13); check_disp("qlim_dec0", disp(2, 0, -1, -1, 0, 0));
        key(15); check_state("qlim_ok0_state", 2);
        for (int i = 0; i < 10; i++) key(12);
        check_disp("qlim_max9", disp(2, 0, -1, -1, 0, 9));
        key(14); check_disp("cancel_qty", disp(0, -1, -1, -1, -1, -1));

        // Key hygiene: long hold is one event, two rows low is none
        key(15); key(2); key(15);
        press_keys(16'h1000, 20);
        check_disp("hold_one", disp(2, 2, -1, -1, 0, 1));
        press_keys(16'h3000, 0);
        check_disp("two_rows", disp(2, 2, -1, -1, 0, 1));

        // Abort from PAY clears everything
        key(15); key(15); key(10);
        check_disp("abort_pay10", disp(4, -1, 0, 3, 1, 0));
        key(14); check_disp("abort_idle", disp(0, -1, -1, -1, -1, -1));
        check_state("abort_state", 0);
        key(15); check_disp("abort_item_clr", disp(1, -1, -1, -1, -1, -1));
        key(4); key(15); key(12); key(15); key(15);
        check_disp("abort_paid_clr", disp(4, -1, 0, 5, 0, 0));

        // Reset pulse in PRICE
        key(14); key(15); key(3); key(15); key(12); key(15);
        check_disp("pre_reset_price", disp(3, -1, 0, 4, 0, 4));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_disp("reset_mid_disp", disp(0, -1, -1, -1, -1, -1));
        check_state("reset_mid_state", 0);
`ifndef VM_EXT_SCAN_EN
        check("reset_mid_col", {44'b0, shift_col}, 48'hE);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        key(15); check_disp("post_reset_sel", disp(1, -1, -1, -1, -1, -1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_machine.md
# vending_machine

Keypad-driven vending-machine controller for the FPGA board top level. It scans a 4x4 active-low matrix keypad and runs a six-state purchase flow: select, quantity, price, payment, change. Progress and amounts are shown on six active-low seven-segment digits. It sits directly between the board keypad/HEX pins and has no other bus interface.

## Interface
- SCAN_DIV, 50000: clock cycles each keypad column stays driven by the internal scanner.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- row  input  4  keypad rows, active-low; row r low means a key in row r is pressed in the currently driven column.
- shift_col  output (input when VM_EXT_SCAN_EN is defined)  4  keypad columns, one-hot active-low.
- D0..D5  output  7 each  seven-segment digits, active-low, bit0=a … bit6=g.
  - D5 is the leftmost digit; D0 is the rightmost.

## Operation
- **Key code.** Key code = 4*col + row, where col and row are the indices of the low bits.
  - 0–7: item select.
  - 8: $1. 9: $5. A: $10. B: $20.
  - C: quantity +1. D: quantity −1. E: cancel. F: OK.
- **Key acceptance.**
  - A key event fires once per press: exactly one row bit is low after at least one cycle with row=1111.
  - More than one row low at once: no event.
  - A held key produces no repeat events.
- **States.** IDLE(0), SELECT(1), QTY(2), PRICE(3), PAY(4), CHANGE(5).
- **Transitions.**
  - IDLE –F→ SELECT.
  - SELECT: key 0–7 stores the item; F with an item stored → QTY; F with no item stored is ignored.
  - QTY: C increments qty, saturating at 9. D decrements qty, saturating at 0. F with qty≥1 → PRICE; F with qty=0 is ignored.
  - PRICE –F→ PAY.
  - PAY: keys 8–B add to paid, saturating at 99. F with paid≥total → CHANGE; F with paid<total is ignored.
  - CHANGE –F→ IDLE, clearing item, qty and paid.
  - E in any state except IDLE → IDLE with everything cleared.
  - Keys not listed for a state are ignored.
- **Arithmetic.**
  - Unit price of item k = k+1 dollars.
  - total = price*qty, range 1–72, held in 7 bits.
  - change = paid−total.
  - All values are shown as two decimal digits with a leading zero.
- **Display.**
  - D5 always shows the state digit.
  - SELECT: D4 = item, or blank if none stored.
  - QTY: D4 = item; D1:D0 = qty.
  - PRICE: D3:D2 = unit price; D1:D0 = total.
  - PAY: D3:D2 = total; D1:D0 = paid.
  - CHANGE: D3:D2 = paid; D1:D0 = change.
  - Unused digits are blank (7'h7F).

## Timing
- row passes through a 2-flop synchronizer. The key event is a 1-cycle pulse, 2 cycles after row goes low.
- State and register updates happen on the edge after the event pulse.
- Displays are decoded combinationally from registers, so they update in the same cycle.
- The internal scanner rotates 1110→1101→1011→0111→1110 every SCAN_DIV cycles. It freezes on the current column while any row is low and resumes after release.
- **Reset values (immediate, asynchronous):**
  - state IDLE; item none; qty 0; paid 0.
  - shift_col 1110 (when driven internally).
  - D5 = "0"; D4..D0 blank.
- Reset asserted mid-purchase aborts the purchase with no other effect.

## Configuration
- VM_EXT_SCAN_EN defined:
  - shift_col becomes an input giving the currently driven column.
  - No internal scanner is built; key decoding uses the external shift_col.
  - This is the simulation mode.
- VM_EXT_SCAN_EN undefined:
  - The internal scanner drives shift_col as an output.

## Structure
- Package vm_pkg holds:
  - state enum;
  - key-code constants (KEY_OK=F, KEY_CANCEL=E, KEY_INC=C, KEY_DEC=D);
  - coin values;
  - price function;
  - seven-segment glyph table for 0–9 and blank.
- Sub-module keypad_scanner holds the column scan, synchronizer, press/release edge detection and key-code output.

## Test plan
- Reset asserted in IDLE: D5=0, D4..D0=7'h7F. With the scanner active, shift_col=1110.
- Normal purchase: keys F, 1, F, C, F, F, 8, 9, F.
  - In CHANGE: D3:D2=06, D1:D0=04.
  - A further F returns to IDLE.
- Underpayment: item 7, qty 2 (total 16), pay $5 then F → stays in PAY, D1:D0=05. Add $20 then F → CHANGE with change 09.
- Quantity limits: in QTY, D from 0 keeps qty 00; ten presses of C give qty 09; F with qty 0 stays in QTY.
- Key hygiene: a key held for 20 cycles gives one event; two rows low at once gives no event.
- Abort: E in PAY → IDLE with paid cleared. Reset pulse mid-PRICE → IDLE, all displays at reset values.
